serial_adder_ctrl: RTL and testbench

Bit-serial multi-bit adder/subtractor controller that sequences a single `one_bit_full_adder` instance over `WIDTH` clock cycles, one bit per cycle, LSB first. The block holds the carry between bits, shifts operands in and result bits out, and presents a start/done handshake to the surrounding datapath. It is the sequencing layer above the one-bit adder cell, trading latency for a single adder slice.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/one_bit_full_adder.sv | 21 ++
 rtl/serial_adder_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor controller:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - default operand width
//   - small decode helper for the Busy status
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Busy covers the whole time an operation owns the adder slice,
    // including the cycle that presents the result.
    function automatic logic state_is_busy(input logic [1:0] state);
        return (state == ST_RUN) || (state == ST_DONE);
    endfunction

endpackage

// File: rtl/one_bit_full_adder.sv
// ---------------------------------------------------------------------------
// one_bit_full_adder
// Single combinational full-adder cell.
// Ports:
//   A, B   in  : operand bits
//   Cin    in  : carry in
//   Sum    out : A ^ B ^ Cin
//   Cout   out : majority(A, B, Cin)
// ---------------------------------------------------------------------------
module one_bit_full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder/subtractor. A single one_bit_full_adder is
// stepped over WIDTH clock cycles, LSB first, with the carry held in a flop.
// Ports:
//   Clk       in  : rising-edge clock
//   Reset     in  : asynchronous active-high reset
//   Start     in  : request an operation (sampled in IDLE only)
//   Sub       in  : 0 = A+B+Cin, 1 = A-B (Cin ignored)
//   A, B      in  : WIDTH-bit operands, sampled with Start
//   Cin       in  : carry-in for add mode, sampled with Start
//   Busy      out : high in RUN and DONE
//   Done      out : one-cycle pulse when Sum/Cout/Overflow are fresh
//   Sum       out : result, held until the next Done
//   Cout      out : carry out of the MSB (0 = borrow in subtract mode)
//   Overflow  out : signed overflow (carry into MSB XOR carry out)
// ---------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] s_sh_q,   s_sh_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             fa_sum;
    logic             fa_cout;

    one_bit_full_adder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    a_sh_d  = A;
                    // Subtraction is A + ~B + 1: invert B and force carry-in.
                    b_sh_d  = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB, so XOR with the
                    // cell's carry out gives signed overflow.
                    sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status outputs decode the state register only, so no input reaches
    // an output combinationally.
    assign Busy     = state_is_busy(state_q);
    assign Done     = (state_q == ST_DONE);
    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl (WIDTH = 8): directed vector
// table, hand-written multi-cycle sequences (ignored Start, mid-run reset)
// and randomized operations against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Overflow;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Sub      (Sub),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Busy     (Busy),
        .Done     (Done),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, output logic [7:0] s, output logic co,
                         output logic ov);
        int unsigned u;
        int          r;
        if (sub) begin
            u = int'(a) + 256 - int'(b);          // >= 256 means no borrow
            r = int'($signed(a)) - int'($signed(b));
        end else begin
            u = int'(a) + int'(b) + int'(cin);
            r = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        s  = u[7:0];
        co = u[8];
        ov = (r > 127) || (r < -128);
    endtask

    // One full operation: Start for one cycle, check latency, Busy length,
    // results and return to idle.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic [7:0] es,
                          input logic ec, input logic eo);
        int n;
        int busy_cnt;
        @(negedge Clk);
        A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
        @(posedge Clk);                 // E0
        #1 Start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (n < 20) begin
            if (Busy) busy_cnt++;
            if (Done) break;
            @(posedge Clk); #1;
            n++;
        end
        chk({name, " latency"}, n, W);
        chk({name, " busy_cycles"}, busy_cnt, W + 1);
        chk({name, " sum"}, int'(Sum), int'(es));
        chk({name, " cout"}, int'(Cout), int'(ec));
        chk({name, " ovf"}, int'(Overflow), int'(eo));
        @(posedge Clk); #1;
        chk({name, " idle_busy"}, int'(Busy), 0);
        chk({name, " idle_done"}, int'(Done), 0);
        chk({name, " sum_held"}, int'(Sum), int'(es));
        $display("op %-10s sub=%0d a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d",
                 name, sub, a, b, cin, Sum, Cout, Overflow, n);
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int done_cnt;
        logic [7:0] ra, rb, es;
        logic rc, rs, ec, eo;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

        Reset = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst sum", int'(Sum), 0);
        chk("rst cout", int'(Cout), 0);
        chk("rst ovf", int'(Overflow), 0);
        chk("rst busy", int'(Busy), 0);
        chk("rst done", int'(Done), 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Directed table
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

        // Start re-asserted at E3 during RUN must be ignored
        @(negedge Clk);
        A = 8'h10; B = 8'h20; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
        @(posedge Clk);                 // E0
        #1 Start = 1'b0;
        repeat (2) @(posedge Clk);      // E1, E2
        @(negedge Clk);
        A = 8'hAA; Start = 1'b1;
        @(posedge Clk);                 // E3
        #1 Start = 1'b0; A = 8'h10;
        n = 3;
        done_cnt = 0;
        while (n < 30) begin
            if (Done) begin
                done_cnt++;
                chk("ignore latency", n, W);
                chk("ignore sum", int'(Sum), 8'h30);
            end
            @(posedge Clk); #1;
            n++;
        end
        chk("ignore done_count", done_cnt, 1);
        $display("op ignore    sum=%02h dones=%0d", Sum, done_cnt);

        // Asynchronous reset between E3 and E4
        @(negedge Clk);
        A = 8'h55; B = 8'h55; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
        @(posedge Clk);                 // E0
        #1 Start = 1'b0;
        repeat (3) @(posedge Clk);      // E3
        #3 Reset = 1'b1;
        #1;
        chk("arst sum", int'(Sum), 0);
        chk("arst cout", int'(Cout), 0);
        chk("arst ovf", int'(Overflow), 0);
        chk("arst busy", int'(Busy), 0);
        chk("arst done", int'(Done), 0);
        chk("arst state", int'(dut.state_q), 0);
        $display("op arst      sum=%02h busy=%0d done=%0d", Sum, Busy, Done);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        run_op("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rc, rs, es, ec, eo);
            run_op($sformatf("rnd%0d", k), ra, rb, rc, rs, es, ec, eo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
